lfsr_challenge_sequencer: RTL
=============================

// Module: lfsr_challenge_sequencer
// PURPOSE
//  Sequences the 16-bit LFSR number generator to build one game round: samples its 4-bit q,
//  filters out-of-range values and immediate repeats, buffers N symbols, then streams them
//  to game control over a valid/ready handshake. Supports replay of the stored round.
//  Sits between LFSR_number_generator (drives its rst, reads its q) and the game-control FSM.
// PARAMETERS
//  MAX_SYM       10   symbols accepted are 0..MAX_SYM-1 (2..16)
//  DEPTH         8    round buffer entries (4 bits each)
//  LEN_W         4    width of round_len, must hold DEPTH
//  SAMPLE_GAP    4    cycles between LFSR samples (>=4 so the nibble is fully refreshed)
//  REJECT_LIMIT  8    consecutive rejects before fallback symbol is forced
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  start      in   1      pulse: generate and present a new round
//  replay     in   1      pulse: re-present last round without regenerating
//  reseed     in   1      pulse: re-initialise LFSR (honoured in IDLE only)
//  round_len  in   LEN_W  symbols per round, valid 1..DEPTH, sampled on start
//  lfsr_q     in   4      q from LFSR_number_generator
//  lfsr_rst   out  1      active-low reset to LFSR_number_generator
//  sym_data   out  4      current symbol
//  sym_valid  out  1      sym_data valid
//  sym_ready  in   1      consumer accepts sym_data
//  sym_last   out  1      high with final symbol of round
//  busy       out  1      high in any state except IDLE
//  done       out  1      1-cycle pulse after final handshake
//  err        out  1      1-cycle pulse on rejected command
// BEHAVIOUR
//  Reset: state=IDLE; lfsr_rst=0; sym_valid, sym_last, busy, done, err=0; sym_data=0;
//   buffer, count, rd_ptr, prev_valid, round_stored cleared. lfsr_rst rises to 1 on first clk after
//   rst deasserts, stays 1 except on reseed. Reset mid-round drops the round (round_stored=0).
//  IDLE: start with round_len in 1..DEPTH -> latch len, clear wr count, reject count, prev_valid; ->GATHER.
//   start with round_len=0 or >DEPTH -> err pulse next cycle, stay IDLE.
//   replay with round_stored=1 -> rd_ptr=0, ->PRESENT; replay with round_stored=0 -> err pulse.
//   reseed -> lfsr_rst=0 for exactly 1 cycle. start wins over replay wins over reseed if simultaneous.
//  GATHER: gap counter counts SAMPLE_GAP cycles, then samples lfsr_q that cycle:
//   accept if lfsr_q<MAX_SYM and (!prev_valid or lfsr_q!=prev); write buf[count], prev=q, rejects=0.
//   else rejects+1; when rejects reaches REJECT_LIMIT, accept fallback=(prev+1) mod MAX_SYM
//   (0 if !prev_valid), rejects=0. After len accepts: round_stored=1, rd_ptr=0, ->PRESENT.
//  PRESENT: sym_valid=1, sym_data=buf[rd_ptr], sym_last=(rd_ptr==len-1). sym_data/sym_last stable
//   while valid&&!ready. On valid&&ready: rd_ptr+1; if last -> sym_valid=0, done pulse, ->IDLE.
//  start/replay/reseed while busy: ignored (no err). Output regs updated on clk; latency start->
//   first sym_valid >= len*SAMPLE_GAP+1 cycles. No back-to-back identical symbols in a round.
// TESTING
//  T1 reset: assert rst mid-GATHER -> all outputs 0, lfsr_rst=0, then 1 next cycle after release.
//  T2 stub lfsr_q per sample 3,3,12,7, len=2 -> stream 3,7; sym_last on 7; done 1 cycle after.
//  T3 stub lfsr_q stuck 15, len=3 -> fallback 0,1,2 each after 8 rejects; then stream 0,1,2.
//  T4 backpressure: hold sym_ready=0 10 cycles -> sym_data/sym_valid stable; then 1 -> advances.
//  T5 round_len=0 and 9 -> err pulse, busy=0; replay before any round -> err; after round -> same data.
//  T6 start during PRESENT ignored; reseed in IDLE -> lfsr_rst low exactly 1 cycle.

Source files
------------

// File: rtl/lfsr_challenge_sequencer_if.sv
// Symbol stream from the challenge sequencer to game control.
// Valid/ready handshake carrying one 4-bit symbol plus an end-of-round flag.
interface lfsr_challenge_sequencer_if;
    logic [3:0] sym_data;
    logic       sym_valid;
    logic       sym_ready;
    logic       sym_last;

    modport master (
        output sym_data,
        output sym_valid,
        output sym_last,
        input  sym_ready
    );

    modport slave (
        input  sym_data,
        input  sym_valid,
        input  sym_last,
        output sym_ready
    );
endinterface

// File: rtl/lfsr_challenge_sequencer.sv
// Builds one game round from LFSR samples, then streams it to game control.
// Filters out-of-range values and immediate repeats; supports replay.
module lfsr_challenge_sequencer #(
    parameter int MAX_SYM      = 10,
    parameter int DEPTH        = 8,
    parameter int LEN_W        = 4,
    parameter int SAMPLE_GAP   = 4,
    parameter int REJECT_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         replay_i,
    input  logic                         reseed_i,
    input  logic [LEN_W-1:0]             round_len_i,
    input  logic [3:0]                   lfsr_q_i,
    output logic                         lfsr_rst_o,
    lfsr_challenge_sequencer_if.master   sym_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GW = $clog2(SAMPLE_GAP + 1);
    localparam int RW = $clog2(REJECT_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, GATHER, PRESENT} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] rd_q, rd_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [RW-1:0]    rej_q, rej_d;
    logic [3:0]       prev_q, prev_d;
    logic             pv_q, pv_d;
    logic             stored_q, stored_d;
    logic             lrst_q, lrst_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [3:0]       mem_q [DEPTH];

    logic             wr_en;
    logic [3:0]       wr_sym;
    logic             len_ok;
    logic             fresh;
    logic             last;
    logic             present;
    logic [4:0]       fb_inc;
    logic [3:0]       fb;

    assign len_ok  = (round_len_i != '0) &&
                     (round_len_i <= LEN_W'(DEPTH));
    assign fresh   = ({1'b0, lfsr_q_i} < 5'(MAX_SYM)) &&
                     (!pv_q || lfsr_q_i != prev_q);
    assign fb_inc  = {1'b0, prev_q} + 5'd1;
    // Fallback steps past the previous symbol so it can never repeat it
    assign fb      = !pv_q ? 4'd0 :
                     (fb_inc == 5'(MAX_SYM)) ? 4'd0 : fb_inc[3:0];
    assign present = (state_q == PRESENT);
    assign last    = (rd_q == len_q - 1'b1);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        gap_d    = gap_q;
        rej_d    = rej_q;
        prev_d   = prev_q;
        pv_d     = pv_q;
        stored_d = stored_q;
        lrst_d   = 1'b1;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        wr_sym   = lfsr_q_i;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_ok) begin
                        len_d   = round_len_i;
                        cnt_d   = '0;
                        rej_d   = '0;
                        gap_d   = '0;
                        pv_d    = 1'b0;
                        state_d = GATHER;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (replay_i) begin
                    if (stored_q) begin
                        rd_d    = '0;
                        state_d = PRESENT;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (reseed_i) begin
                    lrst_d = 1'b0;
                end
            end
            GATHER: begin
                if (gap_q == GW'(SAMPLE_GAP - 1)) begin
                    gap_d = '0;
                    if (fresh) begin
                        wr_en = 1'b1;
                    end else if (rej_q == RW'(REJECT_LIMIT - 1)) begin
                        wr_en  = 1'b1;
                        wr_sym = fb;
                    end else begin
                        rej_d = rej_q + 1'b1;
                    end
                    if (wr_en) begin
                        prev_d = wr_sym;
                        pv_d   = 1'b1;
                        rej_d  = '0;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_d == len_q) begin
                            stored_d = 1'b1;
                            rd_d     = '0;
                            state_d  = PRESENT;
                        end
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            PRESENT: begin
                if (sym_o.sym_ready) begin
                    rd_d = rd_q + 1'b1;
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            gap_q    <= '0;
            rej_q    <= '0;
            prev_q   <= '0;
            pv_q     <= 1'b0;
            stored_q <= 1'b0;
            lrst_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            gap_q    <= gap_d;
            rej_q    <= rej_d;
            prev_q   <= prev_d;
            pv_q     <= pv_d;
            stored_q <= stored_d;
            lrst_q   <= lrst_d;
            done_q   <= done_d;
            err_q    <= err_d;
            if (wr_en) mem_q[cnt_q[IW-1:0]] <= wr_sym;
        end
    end

    assign sym_o.sym_valid = present;
    assign sym_o.sym_data  = present ? mem_q[rd_q[IW-1:0]] : 4'd0;
    assign sym_o.sym_last  = present && last;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign lfsr_rst_o      = lrst_q;
endmodule
